ysyx_25040118_imem_resp: RTL and testbench

//   Instruction-memory responder: the memory side of the instruction-fetch path.

---
 rtl/ysyx_25040118_defs_pkg.sv | 27 ++
 rtl/ysyx_25040118_imem_resp_lfsr8.sv | 34 +++
 rtl/ysyx_25040118_imem_resp.sv | 130 +++++++++++++
 tb/tb_ysyx_25040118_imem_resp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040118_defs_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040118_defs
//   Shared definitions for the instruction-memory responder:
//     VIRT_MEM_BASE / PHYS_MEM_SIZE  default address window of backing memory
//     NOP_INST                       word returned on an access fault
//     IDLE / WAIT / RESP             responder FSM encoding
//     npc_pmem_read()                physical-memory read port
// ---------------------------------------------------------------------------
package ysyx_25040118_defs;

    localparam logic [31:0] VIRT_MEM_BASE = 32'h8000_0000;
    localparam logic [31:0] PHYS_MEM_SIZE = 32'h0800_0000;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Self-contained stand-in for the simulator's physical memory image.
    // The word stored at byte offset p is p ^ 32'h00100093, so offset 0
    // holds "addi x1, x0, 1" and every other word is distinct and
    // address-dependent, which makes wrong-address reads visible.
    function automatic logic [31:0] npc_pmem_read(input logic [31:0] paddr);
        return paddr ^ 32'h0010_0093;
    endfunction

endpackage

// File: rtl/ysyx_25040118_imem_resp_lfsr8.sv
// ---------------------------------------------------------------------------
// ysyx_25040118_lfsr8
//   8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (maximal
//   length). Free-running: advances on every clock once out of reset.
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous reset, active-low; loads seed
//     seed   in   8-bit reset value (must be nonzero)
//     q      out  current LFSR state
// ---------------------------------------------------------------------------
module ysyx_25040118_lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_reg;
    logic       feedback;

    // Taps 8,6,5,4 counted from 1 map to bits 7,5,4,3.
    assign feedback = q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= seed;
        end else begin
            q_reg <= {q_reg[6:0], feedback};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ysyx_25040118_imem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_25040118_imem_resp
//   Memory side of the instruction-fetch path. Accepts one fetch request at
//   a time, waits a programmable latency (optionally with 0..3 cycles of LFSR
//   jitter), reads the word from physical memory and presents it on a
//   valid/ready response channel until the fetch side takes it.
//   Ports:
//     clk        in   system clock
//     rst_n      in   synchronous reset, active-low
//     req_valid  in   fetch request present
//     req_ready  out  responder idle and able to accept (registered decode)
//     req_addr   in   virtual fetch address, sampled at request handshake
//     rsp_valid  out  response present
//     rsp_ready  in   fetch side accepts response
//     rsp_data   out  instruction word, NOP on access fault
//     rsp_err    out  access fault: out of range or misaligned
// ---------------------------------------------------------------------------
module ysyx_25040118_imem_resp
    import ysyx_25040118_defs::*;
#(
    parameter logic [31:0] VIRT_MEM_BASE = ysyx_25040118_defs::VIRT_MEM_BASE,
    parameter logic [31:0] PHYS_MEM_SIZE = ysyx_25040118_defs::PHYS_MEM_SIZE,
    parameter int          LATENCY       = 1,
    parameter bit          RAND_EN       = 1'b0,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    // WAIT counts down to zero, so a latency of L loads L-1.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    logic [1:0]  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic        err_reg, err_next;

    logic [7:0]  lfsr_q;
    logic [7:0]  jitter;
    logic [31:0] phys;
    logic        access_ok;

    ysyx_25040118_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Low two LFSR bits give 0..3 extra wait cycles when jitter is enabled.
    assign jitter = RAND_EN ? (lfsr_q & 8'h03) : 8'h00;

    // 32-bit wrap is intentional: an address below the base underflows to a
    // huge offset and fails the range test instead of aliasing.
    assign phys      = addr_reg - VIRT_MEM_BASE;
    assign access_ok = (phys < PHYS_MEM_SIZE) && (addr_reg[1:0] == 2'b00);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    cnt_next   = LAT_M1 + jitter;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    // The memory read happens only here, once per request,
                    // and only for accesses that pass the checks.
                    if (access_ok) begin
                        data_next = npc_pmem_read(phys);
                        err_next  = 1'b0;
                    end else begin
                        data_next = NOP_INST;
                        err_next  = 1'b1;
                    end
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            addr_reg  <= 32'd0;
            data_reg  <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    // Pure state decodes: no combinational path from either channel input.
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = data_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_ysyx_25040118_imem_resp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040118_imem_resp
//   Two responders share clock and reset: index 0 has LATENCY=1 without
//   jitter, index 1 has LATENCY=3 with LFSR jitter. Expected responses come
//   from an address-level model of the memory window and memory image.
// ---------------------------------------------------------------------------
module tb_ysyx_25040118_imem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_err   [2];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat_lo [2] = '{1, 3};
    int lat_hi [2] = '{1, 6};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_25040118_imem_resp #(.LATENCY(1), .RAND_EN(1'b0)) u_fixed (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
    );

    ysyx_25040118_imem_resp #(.LATENCY(3), .RAND_EN(1'b1)) u_jitter (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
    );

    // Memory image: word at byte offset p is p ^ 32'h00100093.
    function automatic logic [31:0] mem_image(input logic [31:0] offset);
        return offset ^ 32'h0010_0093;
    endfunction

    // Legal window is [0x80000000, 0x88000000) with word alignment.
    function automatic logic exp_err(input logic [31:0] addr);
        return !(addr >= 32'h8000_0000 && addr < 32'h8800_0000 && addr % 4 == 0);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] addr);
        return exp_err(addr) ? 32'h0000_0013 : mem_image(addr - 32'h8000_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    // One request on responder d; optionally holds rsp_ready low for `hold`
    // cycles and keeps req_valid high with a scrambled address after accept.
    task automatic serve(input int d, input logic [31:0] addr, input int hold,
                         input bit scramble, input string tag);
        int k;
        int lat;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        rsp_ready[d] = 1'b0;
        k = 0;
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/accept"}, 32'(k < 50), 32'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                lat = i - 1;
                break;
            end
            if (scramble) req_addr[d] = $urandom;
            else          req_valid[d] = 1'b0;
        end
        chk_rng({tag, "/latency"}, lat, lat_lo[d], lat_hi[d]);
        chk({tag, "/data"}, rsp_data[d], exp_data(addr));
        chk({tag, "/err"}, 32'(rsp_err[d]), 32'(exp_err(addr)));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (scramble) req_addr[d] = $urandom;
            chk({tag, "/hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            chk({tag, "/hold_data"}, rsp_data[d], exp_data(addr));
            chk({tag, "/hold_ready"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b0;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk({tag, "/released"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "/ready_again"}, 32'(req_ready[d]), 32'd1);
        $display("serve %s: d=%0d addr=%h latency=%0d", tag, d, addr, lat);
    endtask

    // Back-to-back sequential requests with rsp_ready tied high; responses
    // are matched in order against a queue of accepted addresses.
    task automatic stream(input int d, input int n, input logic [31:0] base,
                          input int period, input string tag);
        logic [31:0] q_addr[$];
        int          q_acc[$];
        logic [31:0] a;
        int          acc;
        int          issued = 0;
        int          done = 0;
        int          dup = 0;
        int          prev_acc = -1;
        rsp_ready[d] = 1'b1;
        for (int c = 0; c < 20 * n + 50 && done < n; c++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                if (q_addr.size() == 0) begin
                    dup++;
                end else begin
                    a   = q_addr.pop_front();
                    acc = q_acc.pop_front();
                    chk({tag, "/data"}, rsp_data[d], exp_data(a));
                    chk({tag, "/err"}, 32'(rsp_err[d]), 32'(exp_err(a)));
                    chk_rng({tag, "/latency"}, cyc - acc, lat_lo[d], lat_hi[d]);
                    done++;
                end
            end
            if (issued < n) begin
                req_valid[d] = 1'b1;
                req_addr[d]  = base + 32'(4 * issued);
                if (req_ready[d]) begin
                    q_addr.push_back(req_addr[d]);
                    q_acc.push_back(cyc + 1);
                    if (period > 0 && prev_acc >= 0)
                        chk_rng({tag, "/period"}, cyc + 1 - prev_acc, period, period);
                    prev_acc = cyc + 1;
                    issued++;
                end
            end else begin
                req_valid[d] = 1'b0;
            end
        end
        req_valid[d] = 1'b0;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk({tag, "/no_extra"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "/completed"}, 32'(done), 32'(n));
        chk({tag, "/duplicates"}, 32'(dup), 32'd0);
        $display("stream %s: d=%0d issued=%0d completed=%0d", tag, d, issued, done);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          seen;
        int          sel;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d/req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("reset%0d/rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("reset%0d/rsp_data", d), rsp_data[d], 32'd0);
            chk($sformatf("reset%0d/rsp_err", d), 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Basic fetch of the first word, then a stalled response.
        serve(0, 32'h8000_0000, 0, 1'b0, "t1");
        serve(1, 32'h8000_0040, 5, 1'b0, "t2");

        // Window boundaries and faults.
        serve(0, 32'h87FF_FFFC, 0, 1'b0, "t3/last_word");
        serve(0, 32'h8800_0000, 0, 1'b0, "t3/past_end");
        serve(0, 32'h7FFF_FFFC, 0, 1'b0, "t3/below_base");
        serve(0, 32'h8000_0002, 0, 1'b0, "t3/misaligned");
        serve(1, 32'hFFFF_FFFC, 1, 1'b0, "t3/top");

        // Address changes after the handshake must not leak into the response.
        serve(0, 32'h8000_0100, 2, 1'b1, "t6a");
        serve(1, 32'h8000_0200, 3, 1'b1, "t6b");

        // Reset while a request is waiting drops it silently.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0080;
        rsp_ready[1] = 1'b1;
        chk("t4/pre_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("t4/in_wait", 32'(rsp_valid[1]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4/req_ready", 32'(req_ready[1]), 32'd1);
        chk("t4/rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("t4/rsp_data", rsp_data[1], 32'd0);
        chk("t4/rsp_err", 32'(rsp_err[1]), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        chk("t4/dropped", 32'(seen), 32'd0);
        rsp_ready[1] = 1'b0;
        serve(1, 32'h8000_0084, 0, 1'b0, "t4/after");

        // Random mix of legal, misaligned, out-of-range and arbitrary addresses.
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = 32'h8000_0000 + ($urandom_range(0, 32'h01FF_FFFF) << 2);
                1:       a = (32'h8000_0000 + ($urandom_range(0, 32'h01FF_FFFF) << 2))
                             | 32'($urandom_range(1, 3));
                2:       a = 32'h8800_0000 + ($urandom & 32'h0FFF_FFFC);
                default: a = $urandom;
            endcase
            serve(t % 2, a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $sformatf("rand%0d", t));
        end

        // Throughput and in-order streaming.
        stream(0, 30, 32'h8000_1000, 3, "t5/fixed");
        a = 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
        stream(1, 1000, a, 0, "t5/jitter");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
